qpsk_blk_mapper: RTL
====================

QPSK_BLK_MAPPER -- requirements
Module: qpsk_blk_mapper

Interface
REQ-001 Parameter BLK_SIZE, default 384, is the width of the interleaved input block bus; it equals the maximum QPSK Ncbps.
REQ-002 Parameter SYM_W, default 2, is the width of each signed I/Q output sample.
REQ-003 clk  input  1  single clock for the block; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_blk  input  BLK_SIZE  interleaved coded block; bit 0 is transmitted first.
REQ-006 in_blk_valid  input  1  in_blk and ncbps_sel are valid this cycle.
REQ-007 ncbps_sel  input  3  block length select: 0=384, 1=192, 2=96, 3=48, 4=24 bits; 5-7 reserved.
REQ-008 in_blk_ready  output  1  block accepted on a cycle with in_blk_valid and in_blk_ready both high.
REQ-009 sym_i  output  SYM_W  in-phase sample, two's complement.
REQ-010 sym_q  output  SYM_W  quadrature sample, two's complement.
REQ-011 sym_valid  output  1  sym_i, sym_q and sym_last are valid.
REQ-012 sym_ready  input  1  downstream accepts the symbol on a cycle with sym_valid and sym_ready both high.
REQ-013 sym_last  output  1  the current symbol is the final symbol of the block.
REQ-014 len_err  output  1  one-cycle pulse when a block with a reserved ncbps_sel is offered.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-016 In IDLE, in_blk_ready SHALL be 1.
REQ-017 In SEND, in_blk_ready SHALL be 1 only in the cycle where the last symbol handshakes (sym_valid & sym_ready & sym_last); otherwise it SHALL be 0.
REQ-018 On acceptance with valid ncbps_sel, the block SHALL capture in_blk into a holding register and latch Nsym = Ncbps/2 (192/96/48/24/12).
REQ-019 On acceptance with valid ncbps_sel, the block SHALL load the symbol counter with 0 and enter or stay in SEND.
REQ-020 Symbol 0 SHALL appear with sym_valid=1 in the cycle after acceptance (latency 1).
REQ-021 There SHALL be no gap between consecutive blocks accepted back-to-back.
REQ-022 Symbol k SHALL use bit 2k for I and bit 2k+1 for Q; bit 0 maps to +1 (2'b01) and bit 1 maps to -1 (2'b11).
REQ-023 The counter SHALL advance only on a symbol handshake.
REQ-024 While sym_valid=1 and sym_ready=0, sym_i, sym_q and sym_last SHALL hold stable.
REQ-025 sym_last SHALL be 1 exactly when counter = Nsym-1.
REQ-026 On the last handshake with no new block accepted, the FSM SHALL return to IDLE and sym_valid SHALL drop to 0 the next cycle.
REQ-027 Bits at indices >= Ncbps in in_blk SHALL be ignored.
REQ-028 A block offered with ncbps_sel 5-7 while in_blk_ready=1 SHALL be consumed and discarded: no state change, no symbols, and len_err=1 for exactly one cycle.
REQ-029 When sym_valid=0, sym_i and sym_q SHALL be 0.
REQ-030 The counter SHALL be 8 bits wide and SHALL never exceed Nsym-1.

Reset
REQ-031 While reset=1 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear, the holding register SHALL clear, and the outputs SHALL be sym_valid=0, sym_i=0, sym_q=0, sym_last=0, len_err=0.
REQ-032 During any cycle where reset=1, in_blk_ready SHALL be 0.
REQ-033 Reset asserted mid-block SHALL abandon the block: no further symbols, and no sym_last for it.
REQ-034 After reset deasserts, in_blk_ready SHALL be 1 in the first cycle.

Verification
REQ-035 The bench SHALL cover: sel=4, in_blk[23:0]=24'h000000, sym_ready=1 -> 12 symbols (I,Q)=(01,01), sym_last on the 12th only, sym_valid low on the next cycle.
REQ-036 The bench SHALL cover: sel=4, in_blk[3:0]=4'b0110 -> symbol 0 = (I=01,Q=11), symbol 1 = (I=11,Q=01).
REQ-037 The bench SHALL cover: sel=3, with sym_ready toggling randomly -> 24 symbols, each held stable while stalled, with the order and values matching a reference model.
REQ-038 The bench SHALL cover: two sel=0 blocks with in_blk_valid held high -> 384 symbols with no idle cycle between blocks, and in_blk_ready high only on symbol 191 of the first block.
REQ-039 The bench SHALL cover: sel=6 offered in IDLE -> len_err pulses once, in_blk_ready stays 1, and no sym_valid.
REQ-040 The bench SHALL cover: reset asserted after 5 symbols of a sel=1 block -> sym_valid=0 the next cycle, and the next accepted block starts at symbol 0.

Source files
------------

// File: rtl/qpsk_blk_mapper.sv
// QPSK block mapper: captures an interleaved coded block and streams it as
// I/Q symbols (bit 2k -> I, bit 2k+1 -> Q, 0 -> +1, 1 -> -1) under valid/ready.
module qpsk_blk_mapper #(
    parameter int BLK_SIZE = 384,
    parameter int SYM_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BLK_SIZE-1:0] in_blk,
    input  logic                in_blk_valid,
    input  logic [2:0]          ncbps_sel,
    output logic                in_blk_ready,
    output logic [SYM_W-1:0]    sym_i,
    output logic [SYM_W-1:0]    sym_q,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic                sym_last,
    output logic                len_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [BLK_SIZE-1:0] blk;
    logic [7:0]          nsym;
    logic [7:0]          cnt;
    logic [7:0]          nsym_sel;
    logic                sel_ok;
    logic                accept;
    logic                sym_hs;

    function automatic logic [SYM_W-1:0] map_bit(input logic b);
        return b ? '1 : SYM_W'(1);
    endfunction

    always_comb begin
        sel_ok   = 1'b1;
        nsym_sel = 8'd0;
        case (ncbps_sel)
            3'd0:    nsym_sel = 8'd192;
            3'd1:    nsym_sel = 8'd96;
            3'd2:    nsym_sel = 8'd48;
            3'd3:    nsym_sel = 8'd24;
            3'd4:    nsym_sel = 8'd12;
            default: sel_ok   = 1'b0;
        endcase
    end

    assign sym_hs       = sym_valid & sym_ready;
    assign in_blk_ready = !reset && (state == IDLE || (sym_hs && sym_last));
    assign accept       = in_blk_valid & in_blk_ready;

    // The holding register shifts right one symbol per handshake, so the next
    // symbol is always at blk[1:0]; symbol 0 is taken straight from in_blk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            blk       <= '0;
            nsym      <= '0;
            cnt       <= '0;
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
            sym_last  <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (accept && sel_ok) begin
                state     <= SEND;
                blk       <= in_blk >> 2;
                nsym      <= nsym_sel;
                cnt       <= '0;
                sym_valid <= 1'b1;
                sym_i     <= map_bit(in_blk[0]);
                sym_q     <= map_bit(in_blk[1]);
                sym_last  <= 1'b0;
            end else begin
                if (accept)
                    len_err <= 1'b1;
                if (sym_hs) begin
                    if (sym_last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        sym_valid <= 1'b0;
                        sym_i     <= '0;
                        sym_q     <= '0;
                        sym_last  <= 1'b0;
                    end else begin
                        cnt      <= cnt + 8'd1;
                        blk      <= blk >> 2;
                        sym_i    <= map_bit(blk[0]);
                        sym_q    <= map_bit(blk[1]);
                        sym_last <= (cnt + 8'd1 == nsym - 8'd1);
                    end
                end
            end
        end
    end

endmodule
